// File: rtl/store_buffer_if.sv
// Core-side and memory-side signal bundle for the posted-write store buffer.
// slave = the buffer itself; master = core plus backing RAM around it.
interface store_buffer_if #(
    parameter int WIDTH = 32
);
    logic             MemWrite;
    logic [WIDTH-1:0] DataAdr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;
    logic             Stall;
    logic             Empty;
    logic [WIDTH-1:0] MemRdAdr;
    logic [WIDTH-1:0] MemRdData;
    logic             MemValid;
    logic             MemReady;
    logic [WIDTH-1:0] MemAdr;
    logic [WIDTH-1:0] MemWd;

    modport slave (
        input  MemWrite, DataAdr, WriteData, MemRdData, MemReady,
        output ReadData, Stall, Empty, MemRdAdr, MemValid, MemAdr, MemWd
    );

    modport master (
        output MemWrite, DataAdr, WriteData, MemRdData, MemReady,
        input  ReadData, Stall, Empty, MemRdAdr, MemValid, MemAdr, MemWd
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues core stores, drains them to RAM, forwards loads.
// Latency: store visible on MemValid one cycle after acceptance; loads are combinational.
// Backpressure: Stall when full unless a drain frees a slot that cycle; STORE_BUF_MERGE_EN merges same-word stores.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef logic [PW-1:0] ptr_t;

    logic [WIDTH-1:0] adr_q [DEPTH];
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    ptr_t             head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             full, deq, enq, alloc, merge_hit;
    ptr_t             wr_idx, fwd_idx;
    logic [WIDTH-1:0] fwd_dat;

    assign full        = (count_q == CW'(DEPTH));
    assign sb.MemValid = (count_q != '0);
    assign sb.Empty    = (count_q == '0);
    assign sb.MemAdr   = adr_q[head_q];
    assign sb.MemWd    = dat_q[head_q];
    assign sb.MemRdAdr = sb.DataAdr;
    assign deq         = sb.MemValid & sb.MemReady;

`ifdef STORE_BUF_MERGE_EN
    ptr_t merge_idx, scan_idx;

    // Head is excluded: it may be on the RAM bus and must not change under it.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = head_q;
        scan_idx  = head_q;
        for (int i = 1; i < DEPTH; i++) begin
            scan_idx = head_q + ptr_t'(i);
            if (vld_q[scan_idx] && (adr_q[scan_idx][WIDTH-1:2] == sb.DataAdr[WIDTH-1:2])) begin
                merge_hit = 1'b1;
                merge_idx = scan_idx;
            end
        end
    end

    assign wr_idx = merge_hit ? merge_idx : tail_q;
`else
    assign merge_hit = 1'b0;
    assign wr_idx    = tail_q;
`endif

    assign sb.Stall = sb.MemWrite & full & ~deq & ~merge_hit;
    assign enq      = sb.MemWrite & ~sb.Stall;
    assign alloc    = enq & ~merge_hit;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_dat = sb.MemRdData;
        fwd_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + ptr_t'(i);
            if (vld_q[fwd_idx] && (adr_q[fwd_idx][WIDTH-1:2] == sb.DataAdr[WIDTH-1:2])) begin
                fwd_dat = dat_q[fwd_idx];
            end
        end
    end

    assign sb.ReadData = fwd_dat;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        // Clear before set: when full, the freed head slot is the new tail slot.
        if (deq) begin
            head_d        = head_q + ptr_t'(1);
            vld_d[head_q] = 1'b0;
        end
        if (alloc) begin
            tail_d        = tail_q + ptr_t'(1);
            vld_d[tail_q] = 1'b1;
        end
        case ({alloc, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            dat_q[wr_idx] <= sb.WriteData;
        end
        if (alloc) begin
            adr_q[tail_q] <= sb.DataAdr;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: enqueue latency, full/stall, forwarding, drain order, async reset.
module tb_store_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.WIDTH(32)) sif ();
    store_buffer #(.DEPTH(4), .WIDTH(32)) dut (.clk(clk), .reset(reset), .sb(sif));

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] wq[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Apply one cycle of inputs after the falling edge; log the handshake the next rising edge will take.
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        sif.MemWrite  = w;
        sif.DataAdr   = a;
        sif.WriteData = d;
        sif.MemReady  = rdy;
        #1;
        if (sif.MemValid && sif.MemReady) wq.push_back({sif.MemAdr, sif.MemWd});
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] e;
        check_val("wr_present", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
            e = wq.pop_front();
            check_val("wr_adr", e[63:32], a);
            check_val("wr_dat", e[31:0], d);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        sif.MemWrite  = 1'b1;
        sif.DataAdr   = 32'h0;
        sif.WriteData = 32'h0;
        sif.MemReady  = 1'b0;
        sif.MemRdData = 32'hDEAD;
        #2;
        check_val("rst_valid", 32'(sif.MemValid), 32'd0);
        check_val("rst_empty", 32'(sif.Empty), 32'd1);
        check_val("rst_stall", 32'(sif.Stall), 32'd0);
        sif.MemWrite = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic enqueue latency, forwarding, drain order
        drive(1'b1, 32'h60, 32'd5, 1'b0);
        check_val("enq_stall", 32'(sif.Stall), 32'd0);
        check_val("lat_valid0", 32'(sif.MemValid), 32'd0);
        drive(1'b1, 32'h64, 32'd7, 1'b0);
        check_val("lat_valid1", 32'(sif.MemValid), 32'd1);
        check_val("head_adr", sif.MemAdr, 32'h60);
        check_val("head_dat", sif.MemWd, 32'd5);
        drive(1'b0, 32'h64, 32'h0, 1'b0);
        check_val("not_empty", 32'(sif.Empty), 32'd0);
        check_val("fwd_hit", sif.ReadData, 32'd7);
        check_val("rd_adr", sif.MemRdAdr, 32'h64);
        drive(1'b0, 32'h68, 32'h0, 1'b0);
        check_val("fwd_miss", sif.ReadData, 32'hDEAD);
        drive(1'b0, 32'h60, 32'h0, 1'b0);
        check_val("fwd_head", sif.ReadData, 32'd5);
        drain(2);
        check_val("drained_empty", 32'(sif.Empty), 32'd1);
        check_val("drained_valid", 32'(sif.MemValid), 32'd0);
        expect_wr(32'h60, 32'd5);
        expect_wr(32'h64, 32'd7);
        check_val("wr_extra1", 32'(wq.size()), 32'd0);

        // Full: stall, then acceptance when a drain coincides
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
        drive(1'b1, 32'h10, 32'd5, 1'b0);
        check_val("full_stall", 32'(sif.Stall), 32'd1);
        drive(1'b1, 32'h10, 32'd5, 1'b1);
        check_val("full_deq_accept", 32'(sif.Stall), 32'd0);
        drive(1'b1, 32'h14, 32'd6, 1'b0);
        check_val("still_full", 32'(sif.Stall), 32'd1);
        drain(4);
        check_val("full_drained", 32'(sif.Empty), 32'd1);
        expect_wr(32'h00, 32'd1);
        expect_wr(32'h04, 32'd2);
        expect_wr(32'h08, 32'd3);
        expect_wr(32'h0C, 32'd4);
        expect_wr(32'h10, 32'd5);
        check_val("wr_extra2", 32'(wq.size()), 32'd0);

        // Store in flight this cycle is not forwarded until after its edge
        drive(1'b1, 32'h40, 32'h11, 1'b0);
        check_val("fwd_same_cyc", sif.ReadData, 32'hDEAD);
        drive(1'b0, 32'h40, 32'h0, 1'b0);
        check_val("fwd_next_cyc", sif.ReadData, 32'h11);
        drain(1);
        expect_wr(32'h40, 32'h11);

        // Same word twice, first one at head: both allocate, youngest forwards
        drive(1'b1, 32'h20, 32'd1, 1'b0);
        drive(1'b1, 32'h20, 32'd9, 1'b0);
        drive(1'b0, 32'h20, 32'h0, 1'b0);
        check_val("fwd_youngest", sif.ReadData, 32'd9);
        drain(2);
        expect_wr(32'h20, 32'd1);
        expect_wr(32'h20, 32'd9);
        check_val("wr_extra3", 32'(wq.size()), 32'd0);

        // Same word matching a non-head entry
        drive(1'b1, 32'h00, 32'd1, 1'b0);
        drive(1'b1, 32'h20, 32'd1, 1'b0);
        drive(1'b1, 32'h20, 32'd9, 1'b0);
        drive(1'b1, 32'h00, 32'd3, 1'b0);
        drive(1'b0, 32'h20, 32'h0, 1'b0);
        check_val("fwd_merge", sif.ReadData, 32'd9);
        drain(4);
        expect_wr(32'h00, 32'd1);
`ifndef STORE_BUF_MERGE_EN
        expect_wr(32'h20, 32'd1);
`endif
        expect_wr(32'h20, 32'd9);
        expect_wr(32'h00, 32'd3);
        check_val("wr_extra4", 32'(wq.size()), 32'd0);

        // Store to a pending non-head word while full
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
        drive(1'b1, 32'h08, 32'd7, 1'b0);
`ifdef STORE_BUF_MERGE_EN
        check_val("full_merge_stall", 32'(sif.Stall), 32'd0);
`else
        check_val("full_merge_stall", 32'(sif.Stall), 32'd1);
`endif
        drive(1'b0, 32'h08, 32'h0, 1'b0);
`ifdef STORE_BUF_MERGE_EN
        check_val("full_merge_fwd", sif.ReadData, 32'd7);
`else
        check_val("full_merge_fwd", sif.ReadData, 32'd3);
`endif
        drain(4);
        expect_wr(32'h00, 32'd1);
        expect_wr(32'h04, 32'd2);
`ifdef STORE_BUF_MERGE_EN
        expect_wr(32'h08, 32'd7);
`else
        expect_wr(32'h08, 32'd3);
`endif
        expect_wr(32'h0C, 32'd4);
        check_val("wr_extra5", 32'(wq.size()), 32'd0);

        // Asynchronous reset mid-cycle discards pending stores
        drive(1'b1, 32'h80, 32'd1, 1'b0);
        drive(1'b1, 32'h84, 32'd2, 1'b0);
        drive(1'b1, 32'h88, 32'd3, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("pre_rst_valid", 32'(sif.MemValid), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(sif.MemValid), 32'd0);
        check_val("async_rst_empty", 32'(sif.Empty), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drain(3);
        check_val("post_rst_empty", 32'(sif.Empty), 32'd1);
        check_val("post_rst_nowr", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
